ecc_enc_pipe: RTL and testbench

ECC_ENC_PIPE -- requirements
Module: ecc_enc_pipe

---
 rtl/ecc_pkg.sv | 35 +++
 rtl/ecc_enc_core.sv | 49 ++++
 rtl/ecc_enc_pipe.sv | 131 +++++++++++++
 tb/tb_ecc_enc_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: Hamming SEC-DED helpers shared by the encoder and decoder.
// Holds check-bit sizing and the info-bit to codeword-position mapping.
package ecc_pkg;

    // smallest m with 2^m >= m + k + 1
    function automatic int calculate_m(input int k);
        int m;
        m = 1;
        for (int i = 0; i < 30; i++) begin
            if ((1 << m) < m + k + 1) m = m + 1;
        end
        return m;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // codeword position (1-based) of info bit idx: the idx-th
    // non-power-of-2 position counting from 3
    function automatic int info_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= 2 * idx + 4; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_enc_core.sv
// ecc_enc_core: combinational K -> N+1 extended Hamming encoder.
// Ports: d_i info word; q_o codeword with overall parity at LSB or MSB.
module ecc_enc_core
    import ecc_pkg::*;
#(
    parameter int K      = 8,
    parameter int P0_LSB = 1,
    parameter int N      = calculate_m(K) + K
) (
    input  logic [K-1:0] d_i,
    output logic [N:0]   q_o
);

    logic [N:1] dv;
    logic [N:1] cw;
    logic       p0;

    // positions covered by the check bit at power-of-2 position p
    function automatic logic [N:1] cover_mask(input int p);
        logic [N:1] m;
        m = '0;
        for (int q = N; q >= 1; q--) begin
            m = {m[N-1:1], ((q & p) != 0) && (q != p)};
        end
        return m;
    endfunction

    for (genvar i = 0; i < K; i++) begin : g_dat
        assign dv[info_pos(i)] = d_i[i];
    end

    for (genvar p = 1; p <= N; p++) begin : g_pos
        if (is_pow2(p)) begin : g_chk
            assign dv[p] = 1'b0;
            assign cw[p] = ^(dv & cover_mask(p));
        end else begin : g_inf
            assign cw[p] = dv[p];
        end
    end

    assign p0 = ^cw;

    if (P0_LSB != 0) begin : g_lsb
        assign q_o = {cw, p0};
    end else begin : g_msb
        assign q_o = {p0, cw};
    end

endmodule

// File: rtl/ecc_enc_pipe.sv
// ecc_enc_pipe: two-stage valid/ready SEC-DED encoder with error injection
// and a saturating output-word counter.
// Ports: clk_i/rst_ni; d_i/d_valid_i/d_ready_o in; inj_* injection controls;
// q_o/q_valid_o/q_ready_i out; clr_cnt_i/cnt_o transfer counter.
module ecc_enc_pipe
    import ecc_pkg::*;
#(
    parameter int K      = 8,
    parameter int P0_LSB = 1,
    parameter int N      = calculate_m(K) + K,
    parameter int PW     = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [K-1:0]  d_i,
    input  logic          d_valid_i,
    output logic          d_ready_o,
    input  logic          inj_en_i,
    input  logic          inj_dbl_i,
    input  logic [PW-1:0] inj_pos0_i,
    input  logic [PW-1:0] inj_pos1_i,
    output logic [N:0]    q_o,
    output logic          q_valid_o,
    input  logic          q_ready_i,
    input  logic          clr_cnt_i,
    output logic [15:0]   cnt_o
);

    localparam logic [PW-1:0] NPOS = PW'(N);

    logic          a_v_q, a_v_d;
    logic [K-1:0]  a_d_q, a_d_d;
    logic          a_en_q, a_en_d;
    logic          a_dbl_q, a_dbl_d;
    logic [PW-1:0] a_p0_q, a_p0_d;
    logic [PW-1:0] a_p1_q, a_p1_d;
    logic          b_v_q, b_v_d;
    logic [N:0]    b_q_q, b_q_d;
    logic [15:0]   cnt_q, cnt_d;

    logic       a_ld;
    logic       b_ld;
    logic       o_hs;
    logic [N:0] enc;
    logic [N:0] flip;

    assign d_ready_o = !a_v_q || !b_v_q || q_ready_i;
    assign a_ld      = d_valid_i && d_ready_o;
    assign b_ld      = a_v_q && (!b_v_q || q_ready_i);
    assign o_hs      = b_v_q && q_ready_i;

    ecc_enc_core #(
        .K      (K),
        .P0_LSB (P0_LSB),
        .N      (N)
    ) u_core (
        .d_i (a_d_q),
        .q_o (enc)
    );

    // equal positions set the same bit, giving a single flip
    always_comb begin
        flip = '0;
        if (a_en_q) begin
            if (a_p0_q <= NPOS) flip[a_p0_q] = 1'b1;
            if (a_dbl_q && a_p1_q <= NPOS) flip[a_p1_q] = 1'b1;
        end
    end

    always_comb begin
        a_v_d   = a_v_q;
        a_d_d   = a_d_q;
        a_en_d  = a_en_q;
        a_dbl_d = a_dbl_q;
        a_p0_d  = a_p0_q;
        a_p1_d  = a_p1_q;
        b_v_d   = b_v_q;
        b_q_d   = b_q_q;
        cnt_d   = cnt_q;
        if (a_ld) begin
            a_v_d   = 1'b1;
            a_d_d   = d_i;
            a_en_d  = inj_en_i;
            a_dbl_d = inj_dbl_i;
            a_p0_d  = inj_pos0_i;
            a_p1_d  = inj_pos1_i;
        end else if (b_ld) begin
            a_v_d = 1'b0;
        end
        if (b_ld) begin
            b_v_d = 1'b1;
            b_q_d = enc ^ flip;
        end else if (o_hs) begin
            b_v_d = 1'b0;
        end
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (o_hs && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_v_q   <= 1'b0;
            a_d_q   <= '0;
            a_en_q  <= 1'b0;
            a_dbl_q <= 1'b0;
            a_p0_q  <= '0;
            a_p1_q  <= '0;
            b_v_q   <= 1'b0;
            b_q_q   <= '0;
            cnt_q   <= '0;
        end else begin
            a_v_q   <= a_v_d;
            a_d_q   <= a_d_d;
            a_en_q  <= a_en_d;
            a_dbl_q <= a_dbl_d;
            a_p0_q  <= a_p0_d;
            a_p1_q  <= a_p1_d;
            b_v_q   <= b_v_d;
            b_q_q   <= b_q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_o       = b_q_q;
    assign q_valid_o = b_v_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// tb_ecc_enc_pipe: random and directed bench for ecc_enc_pipe (K=8, n=12)
// with a behavioural SEC-DED encoder/decoder reference.
module tb_ecc_enc_pipe;

    localparam int K  = 8;
    localparam int N  = 12;
    localparam int PW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [K-1:0]  d_i = '0;
    logic          d_valid_i = 1'b0;
    logic          d_ready_o;
    logic          inj_en_i = 1'b0;
    logic          inj_dbl_i = 1'b0;
    logic [PW-1:0] inj_pos0_i = '0;
    logic [PW-1:0] inj_pos1_i = '0;
    logic [N:0]    q_o;
    logic          q_valid_o;
    logic          q_ready_i = 1'b0;
    logic          clr_cnt_i = 1'b0;
    logic [15:0]   cnt_o;

    ecc_enc_pipe dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .d_i        (d_i),
        .d_valid_i  (d_valid_i),
        .d_ready_o  (d_ready_o),
        .inj_en_i   (inj_en_i),
        .inj_dbl_i  (inj_dbl_i),
        .inj_pos0_i (inj_pos0_i),
        .inj_pos1_i (inj_pos1_i),
        .q_o        (q_o),
        .q_valid_o  (q_valid_o),
        .q_ready_i  (q_ready_i),
        .clr_cnt_i  (clr_cnt_i),
        .cnt_o      (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N:0]   q;
        logic [K-1:0] d;
        int           nf;
    } exp_t;

    exp_t        eq[$];
    int          total = 0;
    int          bad = 0;
    int          rcv = 0;
    bit          acc = 1'b0;
    logic [15:0] ncnt = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // info bits fill non-power-of-2 positions; check bit p covers i&p
    function automatic logic [N:0] ref_enc(input logic [K-1:0] d);
        logic [N:0] q;
        int         b;
        bit         x;
        q = '0;
        b = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                q[i] = d[b];
                b++;
            end
        end
        for (int p = 1; p <= N; p = p * 2) begin
            x = 1'b0;
            for (int i = 1; i <= N; i++)
                if ((i & p) != 0 && i != p) x = x ^ q[i];
            q[p] = x;
        end
        q[0] = ^q[N:1];
        return q;
    endfunction

    task automatic ref_dec(input logic [N:0] q, output logic [K-1:0] d,
                           output bit sb, output bit db);
        logic [N:0] c;
        int         s;
        int         b;
        s = 0;
        c = q;
        for (int i = 1; i <= N; i++) if (q[i]) s = s ^ i;
        sb = 1'b0;
        db = 1'b0;
        if (^q) begin
            sb = 1'b1;
            if (s != 0 && s <= N) c[s] = ~c[s];
        end else if (s != 0) begin
            db = 1'b1;
        end
        d = '0;
        b = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[b] = c[i];
                b++;
            end
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int   p0;
        int   p1;
        e.d  = d_i;
        e.q  = ref_enc(d_i);
        e.nf = 0;
        p0 = int'(inj_pos0_i);
        p1 = int'(inj_pos1_i);
        if (inj_en_i) begin
            if (p0 <= N) begin
                e.q[p0] = ~e.q[p0];
                e.nf++;
            end
            if (inj_dbl_i && p1 != p0 && p1 <= N) begin
                e.q[p1] = ~e.q[p1];
                e.nf++;
            end
        end
        return e;
    endfunction

    task automatic cyc();
        bit           hold;
        logic [N:0]   hq;
        exp_t         e;
        logic [K-1:0] dd;
        bit           sb;
        bit           db;
        @(negedge clk_i);
        acc  = d_valid_i && d_ready_o;
        hold = q_valid_o && !q_ready_i;
        hq   = q_o;
        if (q_valid_o && q_ready_i) begin
            if (eq.size() == 0) begin
                chk("spurious_word", 1, 0);
            end else begin
                e = eq.pop_front();
                chk("q_stream", 32'(q_o), 32'(e.q));
                ref_dec(q_o, dd, sb, db);
                if (e.nf == 0) begin
                    chk("dec_clean_d", 32'(dd), 32'(e.d));
                    chk("dec_clean_flags", {sb, db}, 0);
                end else if (e.nf == 1) begin
                    chk("dec_sb_flag", 32'(sb), 1);
                    chk("dec_sb_d", 32'(dd), 32'(e.d));
                end else begin
                    chk("dec_db_flag", 32'(db), 1);
                end
            end
            rcv++;
        end
        if (clr_cnt_i) ncnt = '0;
        else if (q_valid_o && q_ready_i && ncnt != 16'hFFFF) ncnt++;
        if (acc) eq.push_back(make_exp());
        @(posedge clk_i);
        #1;
        if (hold) begin
            chk("hold_valid", 32'(q_valid_o), 1);
            chk("hold_q", 32'(q_o), 32'(hq));
        end
    endtask

    task automatic gen(input int w, input int mode);
        int p;
        d_i        = K'($urandom);
        inj_en_i   = 1'b0;
        inj_dbl_i  = 1'b0;
        inj_pos0_i = PW'($urandom_range(15));
        inj_pos1_i = PW'($urandom_range(15));
        case (mode)
            0: begin
                inj_en_i  = ($urandom_range(2) == 0);
                inj_dbl_i = 1'($urandom_range(1));
            end
            1: d_i = K'(w);
            2: begin
                inj_en_i   = 1'b1;
                inj_pos0_i = PW'(w % (N + 1));
            end
            default: begin
                p          = $urandom_range(N);
                inj_en_i   = 1'b1;
                inj_dbl_i  = 1'b1;
                inj_pos0_i = PW'(p);
                inj_pos1_i = PW'((p + 1 + $urandom_range(N - 1)) % (N + 1));
            end
        endcase
    endtask

    task automatic stream(input int nw, input int mode, input bit rnd);
        int sent;
        int r0;
        int budget;
        sent   = 0;
        r0     = rcv;
        budget = nw * 30 + 50;
        acc    = 1'b0;
        d_valid_i = 1'b0;
        while ((rcv - r0) < nw && budget > 0) begin
            if (!d_valid_i || acc) begin
                if (sent < nw && (!rnd || $urandom_range(3) != 0)) begin
                    gen(sent, mode);
                    d_valid_i = 1'b1;
                    sent++;
                end else begin
                    d_valid_i = 1'b0;
                end
            end
            q_ready_i = rnd ? ($urandom_range(2) != 0) : 1'b1;
            cyc();
            budget--;
        end
        if (budget == 0) chk("stream_timeout", rcv - r0, nw);
        d_valid_i = 1'b0;
        inj_en_i  = 1'b0;
        q_ready_i = 1'b1;
        cyc();
    endtask

    // one word on an idle pipe: invisible after 1 edge, valid after 2
    task automatic one(input string tag, input logic [K-1:0] d,
                       input bit en, input bit dbl, input int p0,
                       input int p1, input logic [N:0] exp);
        d_i        = d;
        inj_en_i   = en;
        inj_dbl_i  = dbl;
        inj_pos0_i = PW'(p0);
        inj_pos1_i = PW'(p1);
        d_valid_i  = 1'b1;
        q_ready_i  = 1'b1;
        @(negedge clk_i);
        chk({tag, "_rdy"}, 32'(d_ready_o), 1);
        @(posedge clk_i);
        #1;
        d_valid_i = 1'b0;
        inj_en_i  = 1'b0;
        chk({tag, "_lat1"}, 32'(q_valid_o), 0);
        @(posedge clk_i);
        #1;
        chk({tag, "_lat2"}, 32'(q_valid_o), 1);
        chk({tag, "_q"}, 32'(q_o), 32'(exp));
        @(posedge clk_i);
        #1;
        if (ncnt != 16'hFFFF) ncnt++;
        chk({tag, "_cnt"}, 32'(cnt_o), 32'(ncnt));
        chk({tag, "_drain"}, 32'(q_valid_o), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_qv", 32'(q_valid_o), 0);
        chk("rst_q", 32'(q_o), 0);
        chk("rst_cnt", 32'(cnt_o), 0);
        chk("rst_rdy", 32'(d_ready_o), 1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        one("zero", 8'h00, 0, 0, 0, 0, 13'h0000);
        one("one", 8'h01, 0, 0, 0, 0, 13'h000F);
        one("inj5", 8'h00, 1, 0, 5, 0, 13'h0020);
        one("inj5_0", 8'h00, 1, 1, 5, 0, 13'h0021);
        one("inj15", 8'h00, 1, 0, 15, 0, 13'h0000);
        one("inj_same", 8'h00, 1, 1, 7, 7, 13'h0080);
        one("inj_off", 8'h00, 0, 1, 5, 3, 13'h0000);
        one("inj12", 8'h01, 1, 0, 12, 0, 13'h100F);

        clr_cnt_i = 1'b1;
        cyc();
        clr_cnt_i = 1'b0;
        stream(100, 0, 1'b1);
        chk("cnt_100", 32'(cnt_o), 100);
        stream(256, 1, 1'b0);
        stream(13 * 20, 2, 1'b1);
        stream(60, 3, 1'b1);
        chk("cnt_stream", 32'(cnt_o), 32'(ncnt));

        // fill both stages under backpressure, then reset mid-stream
        q_ready_i = 1'b0;
        d_valid_i = 1'b1;
        d_i       = 8'hA5;
        repeat (3) @(posedge clk_i);
        #1;
        d_valid_i = 1'b0;
        chk("full_qv", 32'(q_valid_o), 1);
        chk("full_rdy", 32'(d_ready_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_qv", 32'(q_valid_o), 0);
        chk("mid_rst_cnt", 32'(cnt_o), 0);
        chk("mid_rst_rdy", 32'(d_ready_o), 1);
        eq.delete();
        ncnt = '0;
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        q_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            chk("no_stale", 32'(q_valid_o), 0);
        end
        one("post_rst", 8'h01, 0, 0, 0, 0, 13'h000F);

        // saturate the counter with continuous traffic
        d_i       = 8'h00;
        d_valid_i = 1'b1;
        q_ready_i = 1'b1;
        repeat (65540) @(posedge clk_i);
        #1;
        d_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("cnt_sat", 32'(cnt_o), 32'hFFFF);
        d_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        d_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("sat_qv", 32'(q_valid_o), 1);
        chk("sat_hold", 32'(cnt_o), 32'hFFFF);
        clr_cnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_cnt_i = 1'b0;
        chk("clr_over_inc", 32'(cnt_o), 0);
        chk("clr_drain", 32'(q_valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
